mips_dmem_mmio: RTL and testbench

Data-memory stage directly downstream of the single-cycle MIPS core.
- Consumes the core's ALU result as the address, plus WriteData and MemWrite.
- Returns ReadData in the same cycle, so load-word completes in one cycle.
- Contains a word-addressed data RAM and a small memory-mapped peripheral region: an 8-bit GPIO output register and a 32-bit timer with compare and interrupt.

---
 rtl/mips_mmio_pkg.sv | 24 ++
 rtl/mmio_timer.sv | 111 +++++++++++
 rtl/mips_dmem_mmio.sv | 72 +++++++
 tb/tb_mips_dmem_mmio.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_mmio_pkg.sv
// Shared constants for the MIPS data-memory stage: MMIO register offsets,
// CTRL/STATUS bit positions and the CMP reset value.
package mips_mmio_pkg;

  typedef enum logic {
    REGION_RAM,
    REGION_MMIO
  } region_e;

  localparam logic [7:0] OFF_GPIO     = 8'h00;
  localparam logic [7:0] OFF_COUNT    = 8'h04;
  localparam logic [7:0] OFF_CMP      = 8'h08;
  localparam logic [7:0] OFF_CTRL     = 8'h0C;
  localparam logic [7:0] OFF_STATUS   = 8'h10;
  localparam logic [7:0] OFF_PRESCALE = 8'h14;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_AUTOCLR_BIT = 1;
  localparam int CTRL_IRQEN_BIT   = 2;
  localparam int STATUS_PEND_BIT  = 0;

  localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_timer.sv
// 32-bit compare timer with sticky pending flag and interrupt enable.
// Build with TIMER_PRESCALE_EN to add the PRESCALE register and prescaler.
module mmio_timer
  import mips_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wrEn_i,
  input  logic [7:0]  off_i,
  input  logic [31:0] wrData_i,
  output logic [31:0] rdData_o,
  output logic        irq_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        pending_q, pending_d;
  logic        enable, tick, match;
  logic [15:0] prescaleVal;

  assign enable = ctrl_q[CTRL_EN_BIT];

`ifdef TIMER_PRESCALE_EN
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] preCnt_q, preCnt_d;

  always_comb begin
    prescale_d = prescale_q;
    preCnt_d   = preCnt_q;
    if (wrEn_i && off_i == OFF_PRESCALE) begin
      prescale_d = wrData_i[15:0];
      preCnt_d   = '0;
    end else if (!enable || preCnt_q == prescale_q) begin
      preCnt_d = '0;
    end else begin
      preCnt_d = preCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q <= '0;
      preCnt_q   <= '0;
    end else begin
      prescale_q <= prescale_d;
      preCnt_q   <= preCnt_d;
    end
  end

  assign tick        = enable && (preCnt_q == prescale_q);
  assign prescaleVal = prescale_q;
`else
  assign tick        = enable;
  assign prescaleVal = '0;
`endif

  assign match = tick && (count_q == cmp_q);

  // Software writes override the increment; a new match beats a W1C.
  always_comb begin
    count_d   = count_q;
    cmp_d     = cmp_q;
    ctrl_d    = ctrl_q;
    pending_d = pending_q;
    if (tick) begin
      count_d = (match && ctrl_q[CTRL_AUTOCLR_BIT]) ? 32'd0 : count_q + 32'd1;
    end
    if (wrEn_i) begin
      case (off_i)
        OFF_COUNT:  count_d = wrData_i;
        OFF_CMP:    cmp_d   = wrData_i;
        OFF_CTRL:   ctrl_d  = wrData_i[2:0];
        OFF_STATUS: if (wrData_i[STATUS_PEND_BIT]) pending_d = 1'b0;
        default:    ;
      endcase
    end
    if (match) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      cmp_q     <= CMP_RESET;
      ctrl_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    rdData_o = '0;
    case (off_i)
      OFF_COUNT:    rdData_o = count_q;
      OFF_CMP:      rdData_o = cmp_q;
      OFF_CTRL:     rdData_o[2:0] = ctrl_q;
      OFF_STATUS:   rdData_o[STATUS_PEND_BIT] = pending_q;
      OFF_PRESCALE: rdData_o[15:0] = prescaleVal;
      default:      rdData_o = '0;
    endcase
  end

  assign irq_o = pending_q && ctrl_q[CTRL_IRQEN_BIT];

endmodule

// File: rtl/mips_dmem_mmio.sv
// Single-cycle data-memory stage: word RAM with async read plus an MMIO page
// holding GPIO and a compare timer (optional prescaler via TIMER_PRESCALE_EN).
module mips_dmem_mmio
  import mips_mmio_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [15:0] MMIO_PAGE   = 16'hFFFF
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic [7:0]  gpio_out,
  output logic        timer_irq
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  region_e          region;
  logic [7:0]       regOff;
  logic [IDX_W-1:0] ramIdx;
  logic             ramWr, mmioWr;
  logic [7:0]       gpio_q;
  logic [31:0]      timerRd;
  logic             unusedAddr;

  assign region     = (Addr[31:16] == MMIO_PAGE) ? REGION_MMIO : REGION_RAM;
  assign regOff     = {Addr[7:2], 2'b00};
  assign ramIdx     = Addr[IDX_W+1:2];
  assign ramWr      = MemWrite && (region == REGION_RAM) && !reset;
  assign mmioWr     = MemWrite && (region == REGION_MMIO);
  assign unusedAddr = ^{Addr[15:8], Addr[1:0]};

  // RAM is deliberately left out of reset; reads see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (ramWr) begin
      mem[ramIdx] <= WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_q <= '0;
    end else if (mmioWr && regOff == OFF_GPIO) begin
      gpio_q <= WriteData[7:0];
    end
  end

  mmio_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .wrEn_i   (mmioWr),
    .off_i    (regOff),
    .wrData_i (WriteData),
    .rdData_o (timerRd),
    .irq_o    (timer_irq)
  );

  always_comb begin
    ReadData = mem[ramIdx];
    if (region == REGION_MMIO) begin
      ReadData = (regOff == OFF_GPIO) ? {24'd0, gpio_q} : timerRd;
    end
  end

  assign gpio_out = gpio_q;

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Self-checking bench for mips_dmem_mmio (default build): directed scenarios
// followed by randomized traffic compared against a behavioural model.
module tb_mips_dmem_mmio;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  int testCount = 0;
  int failCount = 0;

  logic [31:0] mCount, mCmp;
  logic [2:0]  mCtrl;
  logic        mPend;
  logic [7:0]  mGpio;
  logic [31:0] mRam [64];
  bit          mValid [64];

  mips_dmem_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .Addr      (Addr),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    logic [7:0] off;
    off = a[7:0] & 8'hFC;
    if (a[31:16] != 16'hFFFF) return mRam[a[7:2]];
    case (off)
      8'h00:   return {24'd0, mGpio};
      8'h04:   return mCount;
      8'h08:   return mCmp;
      8'h0C:   return {29'd0, mCtrl};
      8'h10:   return {31'd0, mPend};
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelEdge(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic       mmio, hit;
    logic [7:0] off;
    logic [31:0] nextCount;
    mmio = (a[31:16] == 16'hFFFF);
    off  = a[7:0] & 8'hFC;
    hit  = mCtrl[0] && (mCount == mCmp);
    nextCount = mCount;
    if (mCtrl[0]) nextCount = (hit && mCtrl[1]) ? 32'd0 : mCount + 32'd1;
    if (we && mmio && off == 8'h10 && d[0]) mPend = 1'b0;
    if (hit) mPend = 1'b1;
    if (we && mmio) begin
      case (off)
        8'h00:   mGpio = d[7:0];
        8'h04:   nextCount = d;
        8'h08:   mCmp = d;
        8'h0C:   mCtrl = d[2:0];
        default: ;
      endcase
    end
    mCount = nextCount;
    if (we && !mmio) begin
      mRam[a[7:2]]   = d;
      mValid[a[7:2]] = 1'b1;
    end
  endtask

  // One bus cycle: check the combinational read, clock it, check outputs.
  task automatic applyStimulus(input logic we, input logic [31:0] a, input logic [31:0] d);
    MemWrite  = we;
    Addr      = a;
    WriteData = d;
    #2;
    if (a[31:16] == 16'hFFFF || mValid[a[7:2]]) checkOutput("rdata", ReadData, modelRead(a));
    @(posedge clk);
    modelEdge(we, a, d);
    #1;
    checkOutput("gpio", {24'd0, gpio_out}, {24'd0, mGpio});
    checkOutput("irq", {31'd0, timer_irq}, {31'd0, mPend & mCtrl[2]});
    MemWrite = 1'b0;
  endtask

  task automatic expectRead(input string tag, input logic [31:0] a, input logic [31:0] exp);
    MemWrite = 1'b0;
    Addr     = a;
    #2;
    checkOutput(tag, ReadData, exp);
    applyStimulus(1'b0, a, 32'd0);
  endtask

  task automatic doReset();
    reset    = 1'b1;
    MemWrite = 1'b0;
    repeat (2) @(posedge clk);
    mCount = 32'd0;
    mCmp   = 32'hFFFF_FFFF;
    mCtrl  = 3'd0;
    mPend  = 1'b0;
    mGpio  = 8'd0;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d;
    logic [7:0]  off;
    int op;
    reset = 1'b0; Addr = '0; WriteData = '0; MemWrite = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mRam[i] = '0;
      mValid[i] = 1'b0;
    end

    doReset();
    checkOutput("rstGpio", {24'd0, gpio_out}, 32'd0);
    checkOutput("rstIrq", {31'd0, timer_irq}, 32'd0);
    expectRead("rstCmp", 32'hFFFF0008, 32'hFFFF_FFFF);
    expectRead("rstCount", 32'hFFFF0004, 32'd0);

    applyStimulus(1'b1, 32'h0000_0010, 32'hDEADBEEF);
    expectRead("ramLoad", 32'h0000_0010, 32'hDEADBEEF);
    expectRead("ramAlias", 32'h0000_0110, 32'hDEADBEEF);

    applyStimulus(1'b1, 32'hFFFF0008, 32'd5);
    applyStimulus(1'b1, 32'hFFFF000C, 32'd7);
    for (int i = 0; i < 20 && !timer_irq; i++) applyStimulus(1'b0, 32'hFFFF0004, 32'd0);
    checkOutput("irqRise", {31'd0, timer_irq}, 32'd1);
    expectRead("cntClr", 32'hFFFF0004, 32'd0);
    expectRead("status", 32'hFFFF0010, 32'd1);

    for (int i = 0; i < 20 && mCount != 32'd5; i++) applyStimulus(1'b0, 32'hFFFF0004, 32'd0);
    applyStimulus(1'b1, 32'hFFFF0010, 32'd1);
    checkOutput("setWins", {31'd0, timer_irq}, 32'd1);
    applyStimulus(1'b1, 32'hFFFF0010, 32'd1);
    checkOutput("w1cIrq", {31'd0, timer_irq}, 32'd0);
    expectRead("w1cStat", 32'hFFFF0010, 32'd0);

    applyStimulus(1'b1, 32'hFFFF000C, 32'd0);
    applyStimulus(1'b1, 32'hFFFF0008, 32'd10);
    applyStimulus(1'b1, 32'hFFFF0004, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 32'hFFFF000C, 32'd1);
    expectRead("preWrap", 32'hFFFF0004, 32'hFFFF_FFFF);
    expectRead("wrap", 32'hFFFF0004, 32'd0);
    expectRead("noMatch", 32'hFFFF0010, 32'd0);
    applyStimulus(1'b1, 32'hFFFF0004, 32'h0000_1234);
    expectRead("cntWr", 32'hFFFF0004, 32'h0000_1234);
    expectRead("cntInc", 32'hFFFF0004, 32'h0000_1235);

    applyStimulus(1'b1, 32'hFFFF0000, 32'h0000_01A5);
    checkOutput("gpioOut", {24'd0, gpio_out}, 32'h0000_00A5);
    expectRead("gpioRd", 32'hFFFF0000, 32'h0000_00A5);
    expectRead("unmapped", 32'hFFFF0040, 32'd0);
`ifndef TIMER_PRESCALE_EN
    expectRead("prescOff", 32'hFFFF0014, 32'd0);
`endif

    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 7);
      case (op)
        0, 1, 2, 3: begin
          a = {16'($urandom_range(0, 16'hFFFE)), 16'($urandom)};
          applyStimulus(op < 2, a, $urandom);
        end
        4: begin
          off = 8'($urandom_range(0, 4)) << 2;
          case (off)
            8'h04, 8'h08: d = $urandom_range(0, 12);
            8'h0C:        d = $urandom_range(0, 7);
            default:      d = $urandom;
          endcase
          applyStimulus(1'b1, {16'hFFFF, 8'($urandom), off | 8'($urandom_range(0, 3))}, d);
        end
        5, 6: begin
          off = 8'($urandom_range(0, 5)) << 2;
          if (op == 6 && off == 8'h14) off = 8'h40;
`ifdef TIMER_PRESCALE_EN
          if (off == 8'h14) off = 8'h40;
`endif
          applyStimulus(1'b0, {16'hFFFF, 8'($urandom), off}, 32'd0);
        end
        default: applyStimulus(1'b0, 32'hFFFF0004, 32'd0);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
